// File: rtl/gsensor_spi_responder.sv
// rtl/gsensor_spi_responder.sv - SPI mode-3 accelerometer register responder; optional data-ready interrupt via GSENSOR_INT_EN
module gsensor_spi_responder #(
    parameter logic [7:0] DEVID_VAL        = 8'hE5,
    parameter int         SCLK_SYNC_STAGES = 2
) (
    input  logic        MAX10_CLK1_50,
    input  logic        RESET_N,
    input  logic        GSENSOR_CS_N,
    input  logic        GSENSOR_SCLK,
    input  logic        GSENSOR_SDI,
    output logic        GSENSOR_SDO,
    input  logic [15:0] sample_x,
    input  logic [15:0] sample_y,
    input  logic [15:0] sample_z,
    input  logic        sample_valid,
    output logic [2:1]  GSENSOR_INT,
    output logic [7:0]  reg_bw_rate,
    output logic [7:0]  reg_power_ctl,
    output logic [7:0]  reg_data_format
);

    localparam int SYNC_N = (SCLK_SYNC_STAGES < 2) ? 2 : SCLK_SYNC_STAGES;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    logic [SYNC_N-1:0] cs_sync_q, sclk_sync_q, sdi_sync_q;
    logic [SYNC_N:0]   flush_q;
    logic              cs_prev_q, sclk_prev_q;
    logic              cs_s, sclk_s, sdi_s, armed;
    logic              cs_fall, cs_rise, sclk_rise, sclk_fall;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [6:0]  rx_sh_q, rx_sh_d;
    logic [6:0]  tx_sh_q, tx_sh_d;
    logic        sdo_q, sdo_d;
    logic        rw_q, rw_d, mb_q, mb_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  bw_q, bw_d, pwr_q, pwr_d, fmt_q, fmt_d;
    logic [47:0] live_q, live_d, shadow_q, shadow_d;
    logic [7:0]  rx_byte, rdata;

    // Synchronize the SPI pins; flush_q keeps a low CS_N held across reset from looking like a new frame.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '1;
            sdi_sync_q  <= '0;
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b1;
            flush_q     <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_N-2:0], GSENSOR_CS_N};
            sclk_sync_q <= {sclk_sync_q[SYNC_N-2:0], GSENSOR_SCLK};
            sdi_sync_q  <= {sdi_sync_q[SYNC_N-2:0], GSENSOR_SDI};
            cs_prev_q   <= cs_s;
            sclk_prev_q <= sclk_s;
            flush_q     <= {flush_q[SYNC_N-1:0], 1'b1};
        end
    end

    assign cs_s      = cs_sync_q[SYNC_N-1];
    assign sclk_s    = sclk_sync_q[SYNC_N-1];
    assign sdi_s     = sdi_sync_q[SYNC_N-1];
    assign armed     = flush_q[SYNC_N];
    assign cs_fall   = armed & cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign rx_byte   = {rx_sh_q, sdi_s};

    // Register map read mux; sample bytes come from the frame-coherent shadow copy.
    always_comb begin
        rdata = 8'h00;
        case (addr_q)
            6'h00:   rdata = DEVID_VAL;
            6'h2C:   rdata = bw_q;
            6'h2D:   rdata = pwr_q;
            6'h31:   rdata = fmt_q;
            6'h32:   rdata = shadow_q[7:0];
            6'h33:   rdata = shadow_q[15:8];
            6'h34:   rdata = shadow_q[23:16];
            6'h35:   rdata = shadow_q[31:24];
            6'h36:   rdata = shadow_q[39:32];
            6'h37:   rdata = shadow_q[47:40];
            default: rdata = 8'h00;
        endcase
    end

    // Frame FSM plus shift, address and register-write datapath.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_sh_d   = rx_sh_q;
        tx_sh_d   = tx_sh_q;
        sdo_d     = sdo_q;
        rw_d      = rw_q;
        mb_d      = mb_q;
        addr_d    = addr_q;
        bw_d      = bw_q;
        pwr_d     = pwr_q;
        fmt_d     = fmt_q;
        shadow_d  = shadow_q;
        live_d    = sample_valid ? {sample_z, sample_y, sample_x} : live_q;
        if (cs_rise) begin
            state_d   = IDLE;
            bit_cnt_d = 3'd0;
            sdo_d     = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sdo_d     = 1'b0;
                    bit_cnt_d = 3'd0;
                    if (cs_fall) begin
                        state_d  = CMD;
                        shadow_d = live_q;
                    end
                end
                CMD: begin
                    sdo_d = 1'b0;
                    if (sclk_rise) begin
                        rx_sh_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d    = rx_byte[7];
                            mb_d    = rx_byte[6];
                            addr_d  = rx_byte[5:0];
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    // First fall of a byte loads the addressed register, later falls shift it out.
                    if (sclk_fall && rw_q) begin
                        if (bit_cnt_q == 3'd0) begin
                            sdo_d   = rdata[7];
                            tx_sh_d = rdata[6:0];
                        end else begin
                            sdo_d   = tx_sh_q[6];
                            tx_sh_d = {tx_sh_q[5:0], 1'b0};
                        end
                    end
                    if (sclk_rise) begin
                        rx_sh_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (!rw_q) begin
                                case (addr_q)
                                    6'h2C:   bw_d  = rx_byte;
                                    6'h2D:   pwr_d = rx_byte;
                                    6'h31:   fmt_d = rx_byte;
                                    default: ;
                                endcase
                            end
                            if (mb_q) addr_d = addr_q + 6'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            rx_sh_q   <= 7'd0;
            tx_sh_q   <= 7'd0;
            sdo_q     <= 1'b0;
            rw_q      <= 1'b0;
            mb_q      <= 1'b0;
            addr_q    <= 6'd0;
            bw_q      <= 8'h0A;
            pwr_q     <= 8'h00;
            fmt_q     <= 8'h00;
            live_q    <= 48'd0;
            shadow_q  <= 48'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_sh_q   <= rx_sh_d;
            tx_sh_q   <= tx_sh_d;
            sdo_q     <= sdo_d;
            rw_q      <= rw_d;
            mb_q      <= mb_d;
            addr_q    <= addr_d;
            bw_q      <= bw_d;
            pwr_q     <= pwr_d;
            fmt_q     <= fmt_d;
            live_q    <= live_d;
            shadow_q  <= shadow_d;
        end
    end

`ifdef GSENSOR_INT_EN
    logic int1_q, int_clr;

    assign int_clr = (state_q == DATA) && !cs_rise && sclk_rise && (bit_cnt_q == 3'd7)
                     && rw_q && (addr_q == 6'h37);

    // Data-ready flag: a new sample sets it, finishing a read of Z MSB clears it; set wins.
    always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
        if (!RESET_N)          int1_q <= 1'b0;
        else if (sample_valid) int1_q <= 1'b1;
        else if (int_clr)      int1_q <= 1'b0;
    end

    assign GSENSOR_INT = {1'b0, int1_q};
`else
    assign GSENSOR_INT = 2'b00;
`endif

    assign GSENSOR_SDO     = sdo_q;
    assign reg_bw_rate     = bw_q;
    assign reg_power_ctl   = pwr_q;
    assign reg_data_format = fmt_q;

endmodule

// File: tb/tb_gsensor_spi_responder.sv
// tb/tb_gsensor_spi_responder.sv - directed-vector bench for gsensor_spi_responder
module tb_gsensor_spi_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        sclk = 1'b1;
    logic        sdi = 1'b0;
    logic        sdo;
    logic [15:0] sx = '0, sy = '0, sz = '0;
    logic        sv = 1'b0;
    logic [1:0]  int_o;
    logic [7:0]  bw, pwr, fmt;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  rbuf [0:7];
    logic [7:0]  rb;

    always #10 clk = ~clk;

    gsensor_spi_responder dut (
        .MAX10_CLK1_50   (clk),
        .RESET_N         (rst_n),
        .GSENSOR_CS_N    (cs_n),
        .GSENSOR_SCLK    (sclk),
        .GSENSOR_SDI     (sdi),
        .GSENSOR_SDO     (sdo),
        .sample_x        (sx),
        .sample_y        (sy),
        .sample_z        (sz),
        .sample_valid    (sv),
        .GSENSOR_INT     (int_o),
        .reg_bw_rate     (bw),
        .reg_power_ctl   (pwr),
        .reg_data_format (fmt)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Mode-3 byte: SDI changes on the fall, SDO is captured at the rise; optional mid-byte sample strobe.
    task automatic xfer(input logic [7:0] tx, input int nbits, input bit pulse, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            @(negedge clk);
            sclk = 1'b0;
            sdi  = tx[i];
            repeat (HALF) @(negedge clk);
            sclk  = 1'b1;
            rx[i] = sdo;
            repeat (HALF) @(negedge clk);
            if (pulse && i == 4) begin
                sv = 1'b1;
                @(negedge clk);
                sv = 1'b0;
            end
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic cs_end();
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic write_reg(input logic [7:0] cmd, input logic [7:0] data);
        logic [7:0] d;
        cs_begin();
        xfer(cmd, 8, 1'b0, d);
        xfer(data, 8, 1'b0, d);
        cs_end();
    endtask

    task automatic read_frame(input logic [7:0] cmd, input int n, input int pulse_byte);
        logic [7:0] d;
        cs_begin();
        xfer(cmd, 8, 1'b0, d);
        check("sdo_during_cmd", {8'h00, d}, 16'h0000);
        for (int b = 0; b < n; b++) begin
            xfer(8'h00, 8, (b == pulse_byte), d);
            rbuf[b] = d;
        end
        cs_end();
    endtask

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sdo", {15'd0, sdo}, 16'h0000);
        check("rst_int", {14'd0, int_o}, 16'h0000);
        check("rst_bw", {8'h00, bw}, 16'h000A);
        check("rst_pwr", {8'h00, pwr}, 16'h0000);
        check("rst_fmt", {8'h00, fmt}, 16'h0000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Device ID read
        read_frame(8'h80, 1, -1);
        check("devid", {8'h00, rbuf[0]}, 16'h00E5);

        // Write/readback POWER_CTL
        write_reg(8'h2D, 8'h08);
        check("pwr_write", {8'h00, pwr}, 16'h0008);
        read_frame(8'hAD, 1, -1);
        check("pwr_readback", {8'h00, rbuf[0]}, 16'h0008);

        // Write to read-only DEVID ignored
        write_reg(8'h00, 8'h12);
        read_frame(8'h80, 1, -1);
        check("devid_ro", {8'h00, rbuf[0]}, 16'h00E5);

        // Samples and multi-byte burst read
        @(negedge clk);
        sx = 16'h1234; sy = 16'hFFEE; sz = 16'h0100; sv = 1'b1;
        @(negedge clk);
        sv = 1'b0;
        repeat (3) @(negedge clk);
        check("int_tied", {14'd0, int_o}, 16'h0000);
        read_frame(8'hF2, 6, -1);
        check("mb_x_lsb", {8'h00, rbuf[0]}, 16'h0034);
        check("mb_x_msb", {8'h00, rbuf[1]}, 16'h0012);
        check("mb_y_lsb", {8'h00, rbuf[2]}, 16'h00EE);
        check("mb_y_msb", {8'h00, rbuf[3]}, 16'h00FF);
        check("mb_z_lsb", {8'h00, rbuf[4]}, 16'h0000);
        check("mb_z_msb", {8'h00, rbuf[5]}, 16'h0001);

        // New sample mid-frame: frame stays coherent, next frame sees new values
        sx = 16'hA1B2; sy = 16'hC3D4; sz = 16'hE5F6;
        read_frame(8'hF2, 6, 2);
        check("coh_b0", {8'h00, rbuf[0]}, 16'h0034);
        check("coh_b2", {8'h00, rbuf[2]}, 16'h00EE);
        check("coh_b3", {8'h00, rbuf[3]}, 16'h00FF);
        check("coh_b5", {8'h00, rbuf[5]}, 16'h0001);
        read_frame(8'hF2, 6, -1);
        check("new_b0", {8'h00, rbuf[0]}, 16'h00B2);
        check("new_b1", {8'h00, rbuf[1]}, 16'h00A1);
        check("new_b3", {8'h00, rbuf[3]}, 16'h00C3);
        check("new_b4", {8'h00, rbuf[4]}, 16'h00F6);

        // Partial data byte discarded
        cs_begin();
        xfer(8'h31, 8, 1'b0, rb);
        xfer(8'hA5, 4, 1'b0, rb);
        cs_end();
        check("partial_fmt", {8'h00, fmt}, 16'h0000);

        // Address wrap 0x3F -> 0x00 -> 0x01
        read_frame(8'hFF, 3, -1);
        check("wrap_3f", {8'h00, rbuf[0]}, 16'h0000);
        check("wrap_00", {8'h00, rbuf[1]}, 16'h00E5);
        check("wrap_01", {8'h00, rbuf[2]}, 16'h0000);

        // Reset mid-write
        cs_begin();
        xfer(8'h2C, 8, 1'b0, rb);
        xfer(8'h77, 4, 1'b0, rb);
        rst_n = 1'b0;
        #1;
        check("mid_rst_bw", {8'h00, bw}, 16'h000A);
        check("mid_rst_pwr", {8'h00, pwr}, 16'h0000);
        repeat (2) @(negedge clk);
        check("mid_rst_sdo", {15'd0, sdo}, 16'h0000);
        check("mid_rst_int", {14'd0, int_o}, 16'h0000);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_rst_bw", {8'h00, bw}, 16'h000A);
        write_reg(8'h2C, 8'h33);
        check("post_rst_write", {8'h00, bw}, 16'h0033);
        read_frame(8'hAC, 1, -1);
        check("post_rst_read", {8'h00, rbuf[0]}, 16'h0033);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gsensor_spi_responder.md
GSENSOR_SPI_RESPONDER -- requirements
Module: gsensor_spi_responder

Interface
REQ-001 SHALL have parameter DEVID_VAL, default 8'hE5: value returned from register 0x00.
REQ-002 SHALL have parameter SCLK_SYNC_STAGES, default 2: synchronizer depth on GSENSOR_CS_N, GSENSOR_SCLK and GSENSOR_SDI (min 2).
REQ-003 SHALL have port MAX10_CLK1_50 input 1: sole clock, 50 MHz.
REQ-004 SHALL have port RESET_N input 1: asynchronous, active-low reset.
REQ-005 SHALL have port GSENSOR_CS_N input 1: chip select from the SPI initiator, active low.
REQ-006 SHALL have port GSENSOR_SCLK input 1: SPI clock, mode 3 (CPOL=1, CPHA=1), max 6.25 MHz.
REQ-007 SHALL have port GSENSOR_SDI input 1: initiator-to-responder serial data, MSB first.
REQ-008 SHALL have port GSENSOR_SDO output 1: responder-to-initiator serial data, MSB first.
REQ-009 SHALL have ports sample_x, sample_y, sample_z input 16 each: signed acceleration samples.
REQ-010 SHALL have port sample_valid input 1: one-cycle strobe loading the sample_* ports.
REQ-011 SHALL have port GSENSOR_INT output 2: bit 1 = INT1 data-ready, bit 2 = INT2 (tied 0).
REQ-012 SHALL have ports reg_bw_rate, reg_power_ctl, reg_data_format output 8 each: current contents of registers 0x2C, 0x2D and 0x31.

Function
REQ-013 SHALL sample GSENSOR_CS_N, GSENSOR_SCLK and GSENSOR_SDI through SCLK_SYNC_STAGES flops; edge detection SHALL use only the synchronized signals.
REQ-014 SHALL use a state machine IDLE -> CMD -> DATA -> IDLE; a CS_N falling edge moves IDLE->CMD; a CS_N rising edge from any state returns to IDLE.
REQ-015 SHALL sample SDI on each synchronized SCLK rising edge and change SDO on each synchronized SCLK falling edge; SDO updates within 3 clocks of the raw SCLK fall.
REQ-016 SHALL interpret the command byte as bit7 = R/W (1 = read), bit6 = MB (multi-byte), bits5:0 = start address; after its 8th rising edge the state SHALL be DATA.
REQ-017 SHALL, on a read, drive the MSB of the addressed register on the SCLK falling edge following the command byte's 8th rising edge.
REQ-018 SHALL, on a write, commit the received byte to the addressed register 1 clock after the 8th rising edge of each data byte.
REQ-019 SHALL, after each data byte with MB=1, increment the address modulo 64 (0x3F wraps to 0x00); with MB=0 the address SHALL stay fixed.
REQ-020 SHALL implement this register map: 0x00 = DEVID_VAL (read-only); 0x2C, 0x2D, 0x31 read/write; 0x32..0x37 = X LSB, X MSB, Y LSB, Y MSB, Z LSB, Z MSB (read-only); all other addresses SHALL read 8'h00.
REQ-021 SHALL ignore writes to read-only and unmapped addresses.
REQ-022 SHALL load sample_* into live data registers 1 clock after sample_valid.
REQ-023 SHALL copy the live data registers into a shadow set on the CS_N falling edge; reads of 0x32..0x37 SHALL return shadow values, so a frame is coherent even if sample_valid arrives mid-frame.
REQ-024 SHALL discard a partial byte when CS_N rises mid-byte; no register write SHALL occur.
REQ-025 SHALL drive GSENSOR_SDO to 0 while CS_N is high and during the command byte.

Reset
REQ-026 SHALL, on RESET_N low, immediately set: state IDLE; GSENSOR_SDO = 0; GSENSOR_INT = 2'b00; reg_bw_rate = 8'h0A; reg_power_ctl = 8'h00; reg_data_format = 8'h00; live and shadow data = 0; synchronizers = CS_N/SCLK high, SDI 0.
REQ-027 SHALL abort any transaction in progress on reset, and the responder SHALL wait for a fresh CS_N falling edge after reset release.

Configuration
REQ-028 SHALL, when GSENSOR_INT_EN is defined, set GSENSOR_INT[1] 1 clock after sample_valid, and clear it 1 clock after the 8th rising edge of a read byte at address 0x37; set wins over a simultaneous clear.
REQ-029 SHALL, when GSENSOR_INT_EN is undefined, tie GSENSOR_INT to 2'b00 and include no data-ready logic.

Verification
REQ-030 SHALL cover: single read, command 8'h80 -> SDO returns 8'hE5.
REQ-031 SHALL cover: write, command 8'h2D with data 8'h08 -> reg_power_ctl = 8'h08; a following read with command 8'hAD returns 8'h08.
REQ-032 SHALL cover: sample_x=16'h1234, sample_y=16'hFFEE, sample_z=16'h0100, then a multi-byte read with command 8'hF2 for 6 bytes -> 34 12 EE FF 00 01.
REQ-033 SHALL cover: sample_valid pulsed with new values during the 3rd byte of REQ-032 -> all 6 bytes unchanged; the next frame returns the new values.
REQ-034 SHALL cover: command 8'h31, 4 SCLK cycles, then CS_N high -> reg_data_format stays 8'h00; also command 8'hFF reads 3 bytes -> 00 E5 00 (wrap 0x3F->0x00->0x01).
REQ-035 SHALL cover: RESET_N low for 2 clocks mid-write -> all outputs at their reset values and the next transaction is decoded correctly.
